stat_engine_arbiter: RTL and testbench

- Two-requester round-robin arbiter/sequencer in front of the shared digit-statistics engine.
- The engine takes a stream of digits 1..9 with in_valid, then a 0 terminator, then a 2-bit mode one cycle later. It returns one 11-bit result with a one-cycle out_valid.
- This block grants the engine to one requester per transaction, forwards that requester's stream and mode through a single register stage, and routes the engine result back.
- It also enforces a latency timeout on the engine.

---
 rtl/stat_engine_arbiter.sv | 139 +++++++++++++
 tb/tb_stat_engine_arbiter.sv | 535 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stat_engine_arbiter.sv
// Round-robin arbiter/sequencer that lends the shared digit-statistics engine to
// one of two requesters per transaction, with a response-latency timeout.
module stat_engine_arbiter #(
  parameter int TIMEOUT = 100,
  parameter int OUT_W   = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [3:0]       in0,
  input  logic [3:0]       in1,
  input  logic             in_valid0,
  input  logic             in_valid1,
  input  logic [1:0]       mode0,
  input  logic [1:0]       mode1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [OUT_W-1:0] res,
  output logic             res_valid0,
  output logic             res_valid1,
  output logic             timeout,
  output logic [3:0]       eng_in,
  output logic             eng_in_valid,
  output logic [1:0]       eng_mode,
  input  logic [OUT_W-1:0] eng_out,
  input  logic             eng_out_valid
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_STREAM = 3'd1;
  localparam logic [2:0] S_MODE   = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  localparam int               CNT_W       = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  logic [2:0]       state;
  logic             cur;          // requester owning the current transaction
  logic             last_served;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       sel_in;
  logic             sel_valid;
  logic [1:0]       sel_mode;
  logic             pick;
  logic             is_term;

  always_comb begin
    sel_in    = cur ? in1 : in0;
    sel_valid = cur ? in_valid1 : in_valid0;
    sel_mode  = cur ? mode1 : mode0;
    // Contention goes to whoever was not served last; otherwise the lone requester.
    pick      = (req0 && req1) ? ~last_served : req1;
    cnt_inc   = cnt + CNT_W'(1);
    is_term   = sel_valid && (sel_in == 4'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cur          <= 1'b0;
      last_served  <= 1'b1;
      cnt          <= '0;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      res          <= '0;
      res_valid0   <= 1'b0;
      res_valid1   <= 1'b0;
      timeout      <= 1'b0;
      eng_in       <= 4'd0;
      eng_in_valid <= 1'b0;
      eng_mode     <= 2'd0;
    end else begin
      // NOTE: these non-blocking defaults are overridden by any later assignment in
      // the same clock; the last non-blocking write to a register wins.
      eng_in       <= 4'd0;
      eng_in_valid <= 1'b0;
      eng_mode     <= 2'd0;

      case (state)
        S_IDLE: begin
          if (req0 || req1) begin
            cur   <= pick;
            gnt0  <= ~pick;
            gnt1  <= pick;
            state <= S_STREAM;
          end
        end

        S_STREAM: begin
          eng_in       <= sel_in;
          eng_in_valid <= sel_valid;
          if (is_term) state <= S_MODE;
        end

        S_MODE: begin
          // Mode arrives one cycle after the terminator and is shown to the engine
          // for exactly one cycle.
          eng_mode <= sel_mode;
          cnt      <= '0;
          state    <= S_WAIT;
        end

        S_WAIT: begin
          if (eng_out_valid) begin
            res        <= eng_out;
            timeout    <= 1'b0;
            res_valid0 <= ~cur;
            res_valid1 <= cur;
            state      <= S_RESP;
          end else if (cnt_inc == TIMEOUT_CNT) begin
            res        <= '0;
            timeout    <= 1'b1;
            res_valid0 <= ~cur;
            res_valid1 <= cur;
            state      <= S_RESP;
          end else begin
            cnt <= cnt_inc;
          end
        end

        S_RESP: begin
          res_valid0  <= 1'b0;
          res_valid1  <= 1'b0;
          timeout     <= 1'b0;
          gnt0        <= 1'b0;
          gnt1        <= 1'b0;
          last_served <= cur;
          state       <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stat_engine_arbiter.sv
// Bench for stat_engine_arbiter: two requester drivers, a behavioural engine model
// and a transaction-level reference for arbitration order and results.
module tb_stat_engine_arbiter;

  localparam int TIMEOUT = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [3:0]  in0, in1;
  logic        in_valid0, in_valid1;
  logic [1:0]  mode0, mode1;
  logic        gnt0, gnt1;
  logic [10:0] res;
  logic        res_valid0, res_valid1;
  logic        timeout;
  logic [3:0]  eng_in;
  logic        eng_in_valid;
  logic [1:0]  eng_mode;
  logic [10:0] eng_out;
  logic        eng_out_valid;

  stat_engine_arbiter #(.TIMEOUT(TIMEOUT), .OUT_W(11)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .in0(in0), .in1(in1),
    .in_valid0(in_valid0), .in_valid1(in_valid1),
    .mode0(mode0), .mode1(mode1),
    .gnt0(gnt0), .gnt1(gnt1),
    .res(res), .res_valid0(res_valid0), .res_valid1(res_valid1),
    .timeout(timeout),
    .eng_in(eng_in), .eng_in_valid(eng_in_valid), .eng_mode(eng_mode),
    .eng_out(eng_out), .eng_out_valid(eng_out_valid)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  bit          model_last;
  logic [3:0]  txn_digits[$];
  logic [3:0]  obs[$];
  int          lag_err;
  bit          early_rv;
  logic [1:0]  term_mode, mode_at_w, mode_after;
  logic [10:0] got_res;
  logic        got_to;
  int          got_cyc;
  bit          got_seen, got_wrong;

  int          em_latency = 3;
  bit          em_silent = 1'b0;
  bit          em_spurious = 1'b0;

  // Engine statistics: 0 count, 1 max, 2 sum, 3 min of the digits.
  function automatic logic [10:0] ref_result(input logic [3:0] d[$], input logic [1:0] m);
    int acc;
    acc = 0;
    case (m)
      2'd0: acc = d.size();
      2'd1: foreach (d[i]) if (int'(d[i]) > acc) acc = int'(d[i]);
      2'd2: foreach (d[i]) acc += int'(d[i]);
      default: begin
        acc = 15;
        foreach (d[i]) if (int'(d[i]) < acc) acc = int'(d[i]);
        if (d.size() == 0) acc = 0;
      end
    endcase
    return 11'(acc);
  endfunction

  function automatic bit exp_pick(input bit r0, input bit r1, input bit last);
    if (r0 && r1) return !last;
    return r1;
  endfunction

  function automatic bit obs_matches();
    if (obs.size() != txn_digits.size() + 1) return 1'b0;
    foreach (txn_digits[i]) if (obs[i] !== txn_digits[i]) return 1'b0;
    return obs[obs.size()-1] === 4'd0;
  endfunction

  // Engine model: collects digits, reads mode the cycle after the terminator,
  // answers em_latency cycles later (or never when silent).
  int          em_phase = 0;
  int          em_cnt;
  logic [3:0]  em_digits[$];
  logic [10:0] em_res;
  bit          em_spur_done = 1'b0;

  always @(negedge clk) begin
    eng_out_valid = 1'b0;
    if (!em_spurious) em_spur_done = 1'b0;
    if (!rst_n) begin
      em_phase = 0;
      em_digits.delete();
      eng_out = 11'd0;
    end else begin
      case (em_phase)
        0: begin
          if (eng_in_valid) begin
            if (eng_in == 4'd0) em_phase = 1;
            else em_digits.push_back(eng_in);
            if (em_spurious && !em_spur_done && eng_in != 4'd0) begin
              eng_out       = 11'h7FF;
              eng_out_valid = 1'b1;
              em_spur_done  = 1'b1;
            end
          end
        end
        1: begin
          em_res = ref_result(em_digits, eng_mode);
          em_digits.delete();
          em_cnt   = em_latency;
          em_phase = em_silent ? 0 : 2;
        end
        default: begin
          em_cnt--;
          if (em_cnt <= 0) begin
            eng_out       = em_res;
            eng_out_valid = 1'b1;
            em_phase      = 0;
          end
        end
      endcase
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    in0 = 4'd0; in1 = 4'd0; in_valid0 = 1'b0; in_valid1 = 1'b0;
    mode0 = 2'd0; mode1 = 2'd0;
    em_silent = 1'b0; em_spurious = 1'b0; em_latency = 3;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_last = 1'b1;
  endtask

  task automatic fill_digits(input int n);
    txn_digits.delete();
    repeat (n) txn_digits.push_back(4'($urandom_range(1, 9)));
  endtask

  task automatic wait_grant(output int gc);
    gc = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      gc++;
      if (gnt0 || gnt1) break;
    end
  endtask

  task automatic drive(input bit who, input logic v, input logic [3:0] d, input bit noise);
    if (!who) begin in0 = d; in_valid0 = v; end
    else begin in1 = d; in_valid1 = v; end
    if (noise) begin
      if (!who) begin in1 = 4'd5; in_valid1 = ~in_valid1; end
      else begin in0 = 4'd5; in_valid0 = ~in_valid0; end
    end
  endtask

  task automatic tick(input logic v, input logic [3:0] d);
    @(negedge clk);
    if (res_valid0 || res_valid1) early_rv = 1'b1;
    if (eng_in_valid) obs.push_back(eng_in);
    if (eng_in_valid !== v || (v && eng_in !== d)) lag_err++;
  endtask

  // Starts on the cycle the grant is seen; returns one cycle after WAIT entry.
  task automatic stream(input bit who, input logic [1:0] m, input bit gaps, input bit noise);
    lag_err = 0; early_rv = 1'b0; obs.delete();
    mode0 = 2'($urandom); mode1 = 2'($urandom);
    foreach (txn_digits[i]) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          drive(who, 1'b0, 4'($urandom_range(0, 9)), noise);
          tick(1'b0, 4'd0);
        end
      end
      drive(who, 1'b1, txn_digits[i], noise);
      tick(1'b1, txn_digits[i]);
    end
    drive(who, 1'b1, 4'd0, noise);
    tick(1'b1, 4'd0);
    term_mode = eng_mode;
    drive(who, 1'b0, 4'($urandom_range(0, 9)), noise);
    if (!who) mode0 = m; else mode1 = m;
    tick(1'b0, 4'd0);
    mode_at_w = eng_mode;
    if (!who) begin mode0 = 2'($urandom); in_valid1 = 1'b0; end
    else begin mode1 = 2'($urandom); in_valid0 = 1'b0; end
    drive(who, 1'b0, 4'd0, 1'b0);
    tick(1'b0, 4'd0);
    mode_after = eng_mode;
  endtask

  task automatic wait_result(input bit who, input bit keep);
    got_seen = 1'b0; got_wrong = 1'b0; got_cyc = 1;
    got_res = 11'd0; got_to = 1'b0;
    for (int k = 0; k < TIMEOUT + 40; k++) begin
      if (res_valid0 || res_valid1) begin
        got_seen  = 1'b1;
        got_wrong = who ? res_valid0 : res_valid1;
        got_res   = res;
        got_to    = timeout;
        break;
      end
      @(negedge clk);
      got_cyc++;
    end
    if (!keep) begin
      if (!who) req0 = 1'b0; else req1 = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    in0 = 4'd0; in1 = 4'd0; in_valid0 = 1'b0; in_valid1 = 1'b0;
    mode0 = 2'd0; mode1 = 2'd0;
    #12;
    checks++;
    if ({gnt0, gnt1, res_valid0, res_valid1, timeout} !== 5'd0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000", {gnt0, gnt1, res_valid0, res_valid1, timeout});
    end
    checks++;
    if (res !== 11'd0) begin errors++; $display("FAIL reset_res: got %0d want 0", res); end
    checks++;
    if ({eng_in, eng_in_valid, eng_mode} !== 7'd0) begin
      errors++; $display("FAIL reset_eng: got %b want 0", {eng_in, eng_in_valid, eng_mode});
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_last = 1'b1;
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1} !== 2'b00) begin errors++; $display("FAIL reset_idle_gnt: got %b want 00", {gnt1, gnt0}); end
  endtask

  task automatic test_single();
    int gc;
    @(negedge clk);
    req0 = 1'b1;
    txn_digits = '{4'd1, 4'd1, 4'd2};
    em_latency = 3;
    wait_grant(gc);
    checks++;
    if (gc !== 1 || {gnt1, gnt0} !== 2'b01) begin
      errors++; $display("FAIL single_grant: got gnt=%b after %0d cycles want 01 after 1", {gnt1, gnt0}, gc);
    end
    stream(1'b0, 2'd2, 1'b0, 1'b0);
    checks++;
    if (lag_err !== 0 || !obs_matches()) begin
      errors++; $display("FAIL single_stream: lag errors %0d, forwarded digits %0d want 4", lag_err, obs.size());
    end
    checks++;
    if ({term_mode, mode_at_w, mode_after} !== {2'd0, 2'd2, 2'd0}) begin
      errors++; $display("FAIL single_mode: got %0d/%0d/%0d want 0/2/0", term_mode, mode_at_w, mode_after);
    end
    wait_result(1'b0, 1'b0);
    checks++;
    if ({got_seen, got_wrong, got_to} !== 3'b100 || got_res !== 11'd4) begin
      errors++; $display("FAIL single_result: got res=%0d seen=%b wrong=%b to=%b want res=4 on res_valid0", got_res, got_seen, got_wrong, got_to);
    end
    @(negedge clk);
    checks++;
    if ({res_valid0, gnt0, timeout} !== 3'b000 || res !== 11'd4) begin
      errors++; $display("FAIL single_after: got rv0=%b gnt0=%b res=%0d want 0/0/4", res_valid0, gnt0, res);
    end
    model_last = 1'b0;
  endtask

  task automatic test_arbitration();
    int gc;
    bit w;
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    w = exp_pick(1'b1, 1'b1, model_last);
    wait_grant(gc);
    checks++;
    if (gc !== 1 || {gnt1, gnt0} !== (w ? 2'b10 : 2'b01)) begin
      errors++; $display("FAIL arb_first: got gnt=%b after %0d want winner %0d after 1", {gnt1, gnt0}, gc, w);
    end
    fill_digits(3);
    stream(w, 2'd1, 1'b0, 1'b0);
    wait_result(w, 1'b1);
    model_last = w;
    checks++;
    if (got_res !== ref_result(txn_digits, 2'd1) || got_wrong) begin
      errors++; $display("FAIL arb_first_res: got %0d want %0d", got_res, ref_result(txn_digits, 2'd1));
    end
    @(negedge clk);
    checks++;
    if ({gnt1, gnt0} !== 2'b00) begin errors++; $display("FAIL arb_bubble: got %b want 00", {gnt1, gnt0}); end
    w = exp_pick(1'b1, 1'b1, model_last);
    @(negedge clk);
    checks++;
    if ({gnt1, gnt0} !== (w ? 2'b10 : 2'b01)) begin
      errors++; $display("FAIL arb_second: got gnt=%b want winner %0d", {gnt1, gnt0}, w);
    end
    fill_digits(2);
    stream(w, 2'd2, 1'b0, 1'b0);
    wait_result(w, 1'b0);
    model_last = w;
    checks++;
    if (got_res !== ref_result(txn_digits, 2'd2) || got_wrong) begin
      errors++; $display("FAIL arb_second_res: got %0d want %0d", got_res, ref_result(txn_digits, 2'd2));
    end
    @(negedge clk);
    w = exp_pick(req0, req1, model_last);
    @(negedge clk);
    checks++;
    if ({gnt1, gnt0} !== (w ? 2'b10 : 2'b01)) begin
      errors++; $display("FAIL arb_third: got gnt=%b want winner %0d", {gnt1, gnt0}, w);
    end
    fill_digits(2);
    stream(w, 2'd0, 1'b0, 1'b0);
    wait_result(w, 1'b0);
    model_last = w;
    @(negedge clk);
  endtask

  task automatic test_ignore_other();
    int gc;
    int fives;
    @(negedge clk);
    req1 = 1'b1;
    txn_digits.delete();
    repeat (31) txn_digits.push_back(4'd9);
    em_latency = $urandom_range(1, 10);
    wait_grant(gc);
    stream(1'b1, 2'd0, 1'b1, 1'b1);
    fives = 0;
    foreach (obs[i]) if (obs[i] == 4'd5) fives++;
    checks++;
    if (fives !== 0 || lag_err !== 0 || !obs_matches()) begin
      errors++; $display("FAIL ignore_stream: got %0d fives, %0d lag errors, %0d digits want 0/0/32", fives, lag_err, obs.size());
    end
    wait_result(1'b1, 1'b0);
    model_last = 1'b1;
    checks++;
    if (got_res !== 11'd31 || {got_seen, got_wrong} !== 2'b10) begin
      errors++; $display("FAIL ignore_res: got res=%0d seen=%b rv0=%b want 31 on res_valid1 only", got_res, got_seen, got_wrong);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int gc;
    @(negedge clk);
    em_silent = 1'b1;
    req0 = 1'b1;
    fill_digits(4);
    wait_grant(gc);
    stream(1'b0, 2'd3, 1'b1, 1'b0);
    wait_result(1'b0, 1'b0);
    model_last = 1'b0;
    checks++;
    if (got_cyc !== TIMEOUT) begin
      errors++; $display("FAIL timeout_cycles: got %0d want %0d", got_cyc, TIMEOUT);
    end
    checks++;
    if ({got_seen, got_wrong, got_to} !== 3'b101 || got_res !== 11'd0) begin
      errors++; $display("FAIL timeout_flag: got res=%0d to=%b seen=%b want res=0 to=1", got_res, got_to, got_seen);
    end
    @(negedge clk);
    checks++;
    if ({timeout, gnt0, res_valid0} !== 3'b000) begin
      errors++; $display("FAIL timeout_after: got to=%b gnt0=%b rv0=%b want 000", timeout, gnt0, res_valid0);
    end
    em_silent = 1'b0;
    req0 = 1'b1;
    wait_grant(gc);
    checks++;
    if (gc !== 1 || gnt0 !== 1'b1) begin
      errors++; $display("FAIL timeout_regrant: got gnt0=%b after %0d want 1 after 1", gnt0, gc);
    end
    fill_digits(2);
    stream(1'b0, 2'd2, 1'b0, 1'b0);
    wait_result(1'b0, 1'b0);
    checks++;
    if (got_res !== ref_result(txn_digits, 2'd2) || got_to !== 1'b0) begin
      errors++; $display("FAIL timeout_recover: got %0d to=%b want %0d to=0", got_res, got_to, ref_result(txn_digits, 2'd2));
    end
    @(negedge clk);
  endtask

  task automatic test_spurious();
    int gc;
    @(negedge clk);
    req1 = 1'b1;
    fill_digits(3);
    em_latency = 5;
    em_spurious = 1'b1;
    wait_grant(gc);
    stream(1'b1, 2'd2, 1'b0, 1'b0);
    em_spurious = 1'b0;
    checks++;
    if (early_rv !== 1'b0) begin errors++; $display("FAIL spurious_early: got res_valid during stream want none"); end
    wait_result(1'b1, 1'b0);
    model_last = 1'b1;
    checks++;
    if (got_res !== ref_result(txn_digits, 2'd2) || got_wrong) begin
      errors++; $display("FAIL spurious_res: got %0d want %0d", got_res, ref_result(txn_digits, 2'd2));
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int gc;
    logic [1:0] m;
    @(negedge clk);
    req0 = 1'b1;
    wait_grant(gc);
    for (int t = 0; t < 3; t++) begin
      fill_digits($urandom_range(1, 6));
      m = 2'($urandom);
      em_latency = $urandom_range(1, 15);
      stream(1'b0, m, 1'b1, 1'b0);
      wait_result(1'b0, t != 2);
      model_last = 1'b0;
      checks++;
      if (got_res !== ref_result(txn_digits, m) || got_wrong) begin
        errors++; $display("FAIL b2b_res%0d: got %0d want %0d", t, got_res, ref_result(txn_digits, m));
      end
      @(negedge clk);
      if (t != 2) begin
        checks++;
        if (gnt0 !== 1'b0) begin errors++; $display("FAIL b2b_bubble%0d: got gnt0=%b want 0", t, gnt0); end
        @(negedge clk);
        checks++;
        if (gnt0 !== 1'b1) begin errors++; $display("FAIL b2b_regrant%0d: got gnt0=%b want 1", t, gnt0); end
      end
    end
  endtask

  task automatic test_random();
    int gc;
    logic [1:0] r;
    logic [1:0] m;
    bit w;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      r = 2'($urandom_range(1, 3));
      req0 = r[0]; req1 = r[1];
      w = exp_pick(r[0], r[1], model_last);
      m = 2'(i % 4);
      wait_grant(gc);
      checks++;
      if (gc !== 1 || {gnt1, gnt0} !== (w ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL rand_grant%0d: got gnt=%b after %0d want winner %0d", i, {gnt1, gnt0}, gc, w);
      end
      fill_digits($urandom_range(1, 8));
      em_latency = $urandom_range(1, 20);
      stream(w, m, i[0], i[1]);
      wait_result(w, 1'b0);
      req0 = 1'b0; req1 = 1'b0;
      model_last = w;
      checks++;
      if (got_res !== ref_result(txn_digits, m) || {got_seen, got_wrong, got_to} !== 3'b100 ||
          lag_err !== 0 || mode_at_w !== m) begin
        errors++; $display("FAIL rand_txn%0d: got res=%0d mode=%0d lag=%0d want res=%0d mode=%0d", i, got_res, mode_at_w, lag_err, ref_result(txn_digits, m), m);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int gc;
    bit rv_seen;
    @(negedge clk);
    req0 = 1'b1;
    fill_digits(3);
    em_latency = 60;
    wait_grant(gc);
    stream(1'b0, 2'd2, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (gnt0 !== 1'b0) begin errors++; $display("FAIL midrst_gnt: got %b want 0", gnt0); end
    checks++;
    if ({gnt1, res_valid0, res_valid1, timeout, eng_in_valid, eng_mode, eng_in, res} !== 21'd0) begin
      errors++; $display("FAIL midrst_outputs: got res=%0d eng_in=%0d want all 0", res, eng_in);
    end
    req0 = 1'b0;
    rv_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (res_valid0 || res_valid1) rv_seen = 1'b1;
    end
    checks++;
    if (rv_seen !== 1'b0) begin errors++; $display("FAIL midrst_rv: got res_valid during reset want none"); end
    rst_n = 1'b1;
    model_last = 1'b1;
    em_latency = 4;
    req0 = 1'b1;
    wait_grant(gc);
    checks++;
    if (gc !== 1 || {gnt1, gnt0} !== 2'b01) begin
      errors++; $display("FAIL midrst_grant: got gnt=%b after %0d want 01 after 1", {gnt1, gnt0}, gc);
    end
    fill_digits(5);
    stream(1'b0, 2'd1, 1'b0, 1'b0);
    wait_result(1'b0, 1'b0);
    checks++;
    if (got_res !== ref_result(txn_digits, 2'd1) || {got_seen, got_wrong, got_to} !== 3'b100) begin
      errors++; $display("FAIL midrst_txn: got %0d want %0d", got_res, ref_result(txn_digits, 2'd1));
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_arbitration();
    test_ignore_other();
    test_timeout();
    test_spurious();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
